// File: rtl/subpel_conv_arbiter.sv
// Round-robin arbiter sharing one subpel_conv3x3 engine among NUM_REQ requesters,
// with an engine watchdog that aborts a hung job and resets the engine.
module subpel_conv_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic               err,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               eng_start,
  input  logic               eng_done,
  output logic               eng_rst,
  output logic [CNT_W-1:0]   job_count
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SETUP, LAUNCH, WAIT, DONE, ABORT} state_t;

  state_t             state;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   last;
  logic [WD_W-1:0]    wd;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] ack_q;
  logic               err_q;
  logic               busy_q;
  logic               start_q;
  logic               eng_rst_q;

  logic [2*NUM_REQ-1:0] req2;
  logic [NUM_REQ-1:0]   rot;
  logic [SEL_W-1:0]     winner;
  logic                 found;
  logic [NUM_REQ-1:0]   grant_oh;

  // Rotate req so bit 0 is requester (last+1); first set bit is the winner.
  always_comb begin
    req2   = {req, req} >> (32'(last) + 32'd1);
    rot    = req2[NUM_REQ-1:0];
    winner = last;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        winner = SEL_W'((32'(last) + 32'd1 + i) % NUM_REQ);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = (32'(sel_q) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel_q     <= '0;
      last      <= SEL_W'(NUM_REQ - 1);
      wd        <= '0;
      cnt       <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      eng_rst_q <= 1'b0;
    end else begin
      ack_q     <= '0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      eng_rst_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            sel_q  <= winner;
            busy_q <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          start_q <= 1'b1;
          state   <= LAUNCH;
        end
        LAUNCH: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Done wins over a watchdog expiry in the same cycle.
          if (eng_done) begin
            ack_q <= grant_oh;
            state <= DONE;
          end else begin
            wd <= wd + 1'b1;
            if (wd == WD_W'(TIMEOUT - 1)) begin
              ack_q     <= grant_oh;
              err_q     <= 1'b1;
              eng_rst_q <= 1'b1;
              state     <= ABORT;
            end
          end
        end
        DONE: begin
          cnt    <= cnt + 1'b1;
          last   <= sel_q;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        ABORT: begin
          last   <= sel_q;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Outputs show reset values while rst is high; a job in flight gets eng_rst.
  assign ack       = rst ? '0 : ack_q;
  assign err       = err_q & ~rst;
  assign sel       = rst ? '0 : sel_q;
  assign busy      = busy_q & ~rst;
  assign eng_start = start_q & ~rst;
  assign eng_rst   = rst ? busy_q : eng_rst_q;
  assign job_count = rst ? '0 : cnt;

endmodule

// File: tb/tb_subpel_conv_arbiter.sv
// Table-driven bench for subpel_conv_arbiter; expected grants go through a scoreboard queue
// that a negedge monitor pops whenever an ack appears.
module tb_subpel_conv_arbiter;
  localparam int NR = 4;
  localparam int SW = 2;
  localparam int TO = 20;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic          eng_done = 1'b0;
  logic [NR-1:0] ack;
  logic          err;
  logic [SW-1:0] sel;
  logic          busy;
  logic          eng_start;
  logic          eng_rst;
  logic [CW-1:0] job_count;

  subpel_conv_arbiter #(.NUM_REQ(NR), .SEL_W(SW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .err(err), .sel(sel), .busy(busy),
    .eng_start(eng_start), .eng_done(eng_done), .eng_rst(eng_rst), .job_count(job_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;

  typedef struct {
    logic [SW-1:0] sel;
    logic          err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [NR-1:0] r;
    int            delay;   // cycles after eng_start that done rises; 0 = never
    bit            stale;   // done already high before the request
    bit            hold;    // keep req high after ack
    bit            drop;    // drop req once the job is launched
    logic [NR-1:0] glitch;  // short req pulse during WAIT that must be ignored
    logic [SW-1:0] sel;
    bit            err;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    chk("ack_onehot0", 32'($onehot0(ack)), 1);
    chk("start_rst_excl", 32'(eng_start & eng_rst), 0);
    if (ack != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 0);
      end else begin
        e = sb.pop_front();
        chk("ack_vec", 32'(ack), 32'd1 << e.sel);
        chk("err_with_ack", 32'(err), 32'(e.err));
      end
    end else begin
      chk("err_without_ack", 32'(err), 0);
    end
  end

  task automatic do_job(input vec_t v);
    int   ack_k;
    int   exp_k;
    exp_t e;
    ack_k = -1;
    if (v.stale) eng_done = 1'b1;
    req   = v.r;
    e.sel = v.sel;
    e.err = v.err;
    sb.push_back(e);
    @(posedge clk); #1;
    chk("setup_busy", 32'(busy), 1);
    chk("setup_sel", 32'(sel), 32'(v.sel));
    chk("setup_no_start", 32'(eng_start), 0);
    @(posedge clk); #1;
    chk("launch_start", 32'(eng_start), 1);
    chk("launch_sel", 32'(sel), 32'(v.sel));
    chk("launch_no_ack", 32'(ack), 0);
    if (v.drop) req = '0;
    for (int k = 1; k <= 64 && ack_k < 0; k++) begin
      @(posedge clk); #1;
      if (ack != '0) begin
        ack_k = k;
      end else begin
        chk("wait_sel", 32'(sel), 32'(v.sel));
        if (k == v.delay) eng_done = 1'b1;
        if (k == 2) req = req | v.glitch;
        if (k == 3) req = req & ~v.glitch;
      end
    end
    exp_k = v.stale ? 2 : (v.err ? TO + 1 : v.delay + 1);
    chk("ack_latency", 32'(ack_k), 32'(exp_k));
    chk("ack_eng_rst", 32'(eng_rst), 32'(v.err));
    chk("ack_sel", 32'(sel), 32'(v.sel));
    eng_done = 1'b0;
    if (!v.hold) req = '0;
    if (!v.err) exp_count++;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 0);
    chk("job_count", 32'(job_count), 32'(exp_count));
    if (v.glitch != '0) begin
      repeat (3) begin
        @(posedge clk); #1;
        chk("glitch_dropped", 32'(busy), 0);
      end
    end
  endtask

  initial begin
    vec_t last_job;
    //        req      dly stl hld drp glitch   sel  err
    tbl[0]  = '{4'b0001, 12, 0, 0, 0, 4'b0000, 2'd0, 0};
    tbl[1]  = '{4'b1000,  2, 0, 0, 0, 4'b0000, 2'd3, 0};
    tbl[2]  = '{4'b1111,  3, 0, 1, 0, 4'b0000, 2'd0, 0};
    tbl[3]  = '{4'b1111,  3, 0, 1, 0, 4'b0000, 2'd1, 0};
    tbl[4]  = '{4'b1111,  3, 0, 1, 0, 4'b0000, 2'd2, 0};
    tbl[5]  = '{4'b1111,  3, 0, 1, 0, 4'b0000, 2'd3, 0};
    tbl[6]  = '{4'b1111,  3, 0, 0, 0, 4'b0000, 2'd0, 0};
    tbl[7]  = '{4'b0100,  0, 0, 0, 0, 4'b0000, 2'd2, 1};
    tbl[8]  = '{4'b0010,  5, 0, 0, 0, 4'b0000, 2'd1, 0};
    tbl[9]  = '{4'b0101,  0, 1, 0, 0, 4'b0000, 2'd2, 0};
    tbl[10] = '{4'b1001, TO, 0, 0, 0, 4'b0000, 2'd3, 0};
    tbl[11] = '{4'b0110,  4, 0, 0, 1, 4'b0001, 2'd1, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_start", 32'(eng_start), 0);
    chk("rst_eng_rst", 32'(eng_rst), 0);
    chk("rst_count", 32'(job_count), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_rst", 32'(busy), 0);

    for (int i = 0; i < 12; i++) do_job(tbl[i]);

    // Reset while the engine is running: no ack, engine reset, priority back to req[0].
    req = 4'b0100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_launch", 32'(eng_start), 1);
    req = '0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_busy_before", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("midrst_eng_rst", 32'(eng_rst), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ack", 32'(ack), 0);
    chk("midrst_sel", 32'(sel), 0);
    chk("midrst_start", 32'(eng_start), 0);
    chk("midrst_count", 32'(job_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_count = 0;
    #1;
    chk("postrst_eng_rst", 32'(eng_rst), 0);
    chk("postrst_busy", 32'(busy), 0);
    last_job = '{4'b1111, 5, 0, 0, 0, 4'b0000, 2'd0, 0};
    do_job(last_job);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/subpel_conv_arbiter.md
SUBPEL_CONV_ARBITER -- requirements
Module: subpel_conv_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one subpel_conv3x3 engine.
REQ-002 The block SHALL have parameter SEL_W, default 2, giving the width of the requester index (>= clog2(NUM_REQ)).
REQ-003 The block SHALL have parameter TIMEOUT, default 1023, giving the watchdog limit in WAIT cycles.
REQ-004 The block SHALL have parameter CNT_W, default 16, giving the completed-job counter width.
REQ-005 The block SHALL have port clk, input, 1 bit, as its single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, as its reset; reset is synchronous and active-high.
REQ-007 The block SHALL have port req, input, NUM_REQ bits: level request per requester, held until ack.
REQ-008 The block SHALL have port ack, output, NUM_REQ bits: one-cycle completion pulse to the granted requester.
REQ-009 The block SHALL have port err, output, 1 bit: one-cycle pulse coincident with ack when a job times out.
REQ-010 The block SHALL have port sel, output, SEL_W bits: index of the requester whose tensor/weights/bias are muxed onto the engine.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port eng_start, output, 1 bit: one-cycle start pulse to the engine.
REQ-013 The block SHALL have port eng_done, input, 1 bit: engine done, level or pulse.
REQ-014 The block SHALL have port eng_rst, output, 1 bit: one-cycle engine reset pulse on abort.
REQ-015 The block SHALL have port job_count, output, CNT_W bits: count of successfully completed jobs, wrapping modulo 2^CNT_W.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, LAUNCH, WAIT, DONE and ABORT.
REQ-017 In IDLE with any req bit high, the block SHALL register the round-robin winner into sel and move to SETUP; with req==0 it SHALL stay in IDLE.
REQ-018 Round-robin search SHALL start at (last+1) mod NUM_REQ, where last is the most recently served index.
REQ-019 The block SHALL update last in DONE and in ABORT.
REQ-020 SETUP SHALL last exactly 1 cycle to settle the input mux, then move to LAUNCH.
REQ-021 LAUNCH SHALL assert eng_start for exactly 1 cycle, clear the watchdog counter and move to WAIT.
REQ-022 eng_done SHALL be ignored in SETUP and LAUNCH, so a stale done from the previous job is not counted.
REQ-023 In WAIT, eng_done=1 SHALL move to DONE; otherwise the watchdog SHALL increment.
REQ-024 In WAIT, when the watchdog equals TIMEOUT with eng_done=0, the block SHALL move to ABORT.
REQ-025 When eng_done=1 in the same cycle the watchdog reaches TIMEOUT, done SHALL win.
REQ-026 DONE SHALL, for 1 cycle, pulse ack[sel] and increment job_count, then return to IDLE.
REQ-027 ABORT SHALL, for 1 cycle, pulse ack[sel], err and eng_rst with job_count unchanged, then return to IDLE.
REQ-028 sel SHALL be stable from SETUP through DONE/ABORT.
REQ-029 At most one ack bit SHALL be high in any cycle.
REQ-030 eng_start and eng_rst SHALL never be high in the same cycle.
REQ-031 Latency SHALL be: req sampled in IDLE at cycle t -> eng_start at t+2; eng_done sampled at cycle u -> ack at u+1; back-to-back jobs -> next eng_start 3 cycles after ack.
REQ-032 A requester dropping req while granted SHALL NOT cancel its job; ack is still issued.
REQ-033 A req deasserted before it is granted SHALL be dropped silently.
REQ-034 req still high in the cycle after ack SHALL be treated as a new request, subject to round-robin rotation.

Reset
REQ-035 While rst=1 the block SHALL force: state=IDLE, sel=0, busy=0, ack=0, err=0, eng_start=0, eng_rst=0, job_count=0, watchdog=0, last=NUM_REQ-1 (so req[0] has first priority).
REQ-036 rst asserted mid-job SHALL abandon the job with no ack and SHALL assert eng_rst for that reset cycle.

Verification
REQ-037 Single request, NUM_REQ=4: req=0001, engine model returns done 12 cycles after start -> eng_start 2 cycles after req; sel=0; ack=0001 one cycle after done; job_count=1; err=0.
REQ-038 Contention, all four held high, 4 jobs -> grant order sel=0,1,2,3; then wrap to 0; exactly one ack per job.
REQ-039 Timeout, TIMEOUT=20, engine never done -> ABORT after 20 WAIT cycles; ack, err and eng_rst pulse together; job_count unchanged; next request still served.
REQ-040 Stale done, eng_done held high from a prior job through SETUP/LAUNCH -> no DONE before WAIT; then completes on the first WAIT cycle.
REQ-041 Tie, eng_done rises on the exact TIMEOUT cycle -> DONE taken, err=0, job_count increments.
REQ-042 Reset mid-WAIT, rst pulsed during WAIT -> no ack; eng_rst=1 during reset; all outputs at reset values; req[0] wins the next arbitration.
